// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: stereo sample buffer feeding the I2S output stage.
// Storage is a (DEPTH-1)-entry synchronous-read RAM plus a head register that
// presents a first-word-fall-through sample to the I2S reader.
// Optional feature macro: AUDIO_SAMPLE_FIFO_REPEAT_EN -- when defined, the head
// data keeps the last popped sample after the FIFO drains instead of going to 0.
module audio_sample_fifo #(
    parameter int DEPTH         = 512,
    parameter int ADDR_W        = 9,
    parameter int LOW_THRESHOLD = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inport_tvalid_i,
    input  logic [31:0]       inport_tdata_i,
    input  logic              inport_tlast_i,
    output logic              inport_tready_o,
    output logic              outport_tvalid_o,
    output logic [31:0]       outport_tdata_o,
    input  logic              outport_tready_i,
    input  logic              flush_i,
    input  logic              underrun_clr_i,
    output logic [ADDR_W:0]   level_o,
    output logic              low_o,
    output logic              underrun_o,
    output logic [15:0]       underrun_cnt_o
);

    localparam int LVL_W = ADDR_W + 1;
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_LOW  = LVL_W'(LOW_THRESHOLD);
    localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0]  LVL_ZERO = '0;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 2);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [31:0]       ram [0:DEPTH-2];
    logic [31:0]       ram_rdata;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr_inc;
    logic [ADDR_W-1:0] rd_ptr_inc;
    logic [ADDR_W-1:0] rd_addr_next;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_next;
    logic              head_valid;
    logic [31:0]       head_data;
    logic              fresh_q;
    logic              low_q;
    logic              underrun_q;
    logic [15:0]       underrun_cnt_q;

    logic push_req;
    logic pop_ok;
    logic underrun_pop;
    logic ram_empty;
    logic head_load_in;
    logic head_load_ram;
    logic ram_wr;
    logic rd_adv;
    logic unused_tlast;

    // Frame markers carry no meaning for a continuous sample stream.
    assign unused_tlast = inport_tlast_i;

    assign inport_tready_o = (level_q != LVL_FULL);
    assign push_req        = inport_tvalid_i && inport_tready_o;
    // A pop the cycle after an empty-to-valid load refers to the stale head
    // the reader latched earlier, so it is treated as an underrun instead.
    assign pop_ok          = outport_tready_i && head_valid && !fresh_q;
    assign underrun_pop    = outport_tready_i && (!head_valid || fresh_q) && !flush_i;
    assign ram_empty       = (level_q == (head_valid ? LVL_ONE : LVL_ZERO));
    // Input goes straight to the head when there is no head, or when the last
    // head is popped with nothing queued behind it (gapless hand-over).
    assign head_load_in    = push_req && (!head_valid || (pop_ok && ram_empty));
    assign head_load_ram   = pop_ok && !ram_empty;
    assign ram_wr          = push_req && !head_load_in && !flush_i;
    assign rd_adv          = head_load_ram && !flush_i;

    assign wr_ptr_inc = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
    assign rd_ptr_inc = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;

    // Next fill level and the RAM address to prefetch for the following cycle.
    always_comb begin
        level_next   = level_q;
        rd_addr_next = rd_ptr;
        if (flush_i) begin
            level_next   = '0;
            rd_addr_next = '0;
        end else begin
            if (push_req && !pop_ok) begin
                level_next = level_q + LVL_ONE;
            end else if (!push_req && pop_ok) begin
                level_next = level_q - LVL_ONE;
            end
            if (rd_adv) begin
                rd_addr_next = rd_ptr_inc;
            end
        end
    end

    // Sample RAM with a registered read of the next head candidate; a write to
    // that same slot is forwarded so the prefetch never returns stale data.
    always_ff @(posedge clk_i) begin
        if (ram_wr) begin
            ram[wr_ptr] <= inport_tdata_i;
        end
        if (ram_wr && (wr_ptr == rd_addr_next)) begin
            ram_rdata <= inport_tdata_i;
        end else begin
            ram_rdata <= ram[rd_addr_next];
        end
    end

    // Pointers, fill level, head register and the fresh-load marker.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            low_q      <= 1'b1;
            head_valid <= 1'b0;
            head_data  <= '0;
            fresh_q    <= 1'b0;
        end else begin
            level_q <= level_next;
            low_q   <= (level_next < LVL_LOW);
            if (flush_i) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                head_valid <= 1'b0;
                head_data  <= '0;
                fresh_q    <= 1'b0;
            end else begin
                if (ram_wr) begin
                    wr_ptr <= wr_ptr_inc;
                end
                if (rd_adv) begin
                    rd_ptr <= rd_ptr_inc;
                end
                fresh_q <= head_load_in && !head_valid;
                if (head_load_in) begin
                    head_valid <= 1'b1;
                    head_data  <= inport_tdata_i;
                end else if (head_load_ram) begin
                    head_valid <= 1'b1;
                    head_data  <= ram_rdata;
                end else if (pop_ok) begin
                    head_valid <= 1'b0;
`ifdef AUDIO_SAMPLE_FIFO_REPEAT_EN
                    head_data  <= head_data;
`else
                    head_data  <= '0;
`endif
                end
            end
        end
    end

    // Sticky underrun flag and saturating count; a clear that coincides with
    // an underrun pop leaves that one pop recorded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else if (underrun_clr_i) begin
            underrun_q     <= underrun_pop;
            underrun_cnt_q <= underrun_pop ? 16'd1 : 16'd0;
        end else if (underrun_pop) begin
            underrun_q <= 1'b1;
            if (underrun_cnt_q != 16'hFFFF) begin
                underrun_cnt_q <= underrun_cnt_q + 16'd1;
            end
        end
    end

    assign outport_tvalid_o = head_valid;
    assign outport_tdata_o  = head_data;
    assign level_o          = level_q;
    assign low_o            = low_q;
    assign underrun_o       = underrun_q;
    assign underrun_cnt_o   = underrun_cnt_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo: a constant vector table for the
// short corner sequences, hand-written fill/flush/reset sequences, and a
// randomized run checked against a queue-based reference model.
module tb_audio_sample_fifo;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int LOW    = 128;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              inport_tvalid_i;
    logic [31:0]       inport_tdata_i;
    logic              inport_tlast_i;
    logic              inport_tready_o;
    logic              outport_tvalid_o;
    logic [31:0]       outport_tdata_o;
    logic              outport_tready_i;
    logic              flush_i;
    logic              underrun_clr_i;
    logic [ADDR_W:0]   level_o;
    logic              low_o;
    logic              underrun_o;
    logic [15:0]       underrun_cnt_o;

    audio_sample_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LOW_THRESHOLD(LOW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inport_tvalid_i(inport_tvalid_i), .inport_tdata_i(inport_tdata_i),
        .inport_tlast_i(inport_tlast_i), .inport_tready_o(inport_tready_o),
        .outport_tvalid_o(outport_tvalid_o), .outport_tdata_o(outport_tdata_o),
        .outport_tready_i(outport_tready_i), .flush_i(flush_i),
        .underrun_clr_i(underrun_clr_i), .level_o(level_o), .low_o(low_o),
        .underrun_o(underrun_o), .underrun_cnt_o(underrun_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: the queue holds every stored sample, head first.
    logic [31:0] mq[$];
    bit          mFresh;
    logic [31:0] mHold;
    bit          mUflag;
    int          mUcnt;

    typedef struct {
        logic        push;
        logic [31:0] data;
        logic        pop;
        logic        clr;
        logic        expValid;
        logic [31:0] expData;
        int          expLevel;
        int          expUcnt;
        logic        expUflag;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [31:0] rep(input logic [31:0] v);
`ifdef AUDIO_SAMPLE_FIFO_REPEAT_EN
        return v;
`else
        return 32'h0;
`endif
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mFresh = 0;
        mHold  = '0;
        mUflag = 0;
        mUcnt  = 0;
    endtask

    task automatic resetDut();
        inport_tvalid_i  = 0;
        inport_tdata_i   = '0;
        outport_tready_i = 0;
        flush_i          = 0;
        underrun_clr_i   = 0;
        rst_i = 1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 0;
        modelReset();
    endtask

    // Drives one cycle of inputs, advances the model by the same rules, then
    // waits past the edge so outputs can be sampled.
    task automatic applyStimulus(input logic push, input logic [31:0] data, input logic pop,
                                 input logic flush, input logic clr);
        bit wasEmpty, pushed, upop, gpop;
        inport_tvalid_i  = push;
        inport_tdata_i   = data;
        outport_tready_i = pop;
        flush_i          = flush;
        underrun_clr_i   = clr;
        wasEmpty = (mq.size() == 0);
        pushed   = push && (mq.size() != DEPTH);
        upop     = !flush && pop && (wasEmpty || mFresh);
        gpop     = !flush && pop && !upop;
        if (flush) begin
            mq.delete();
            mFresh = 0;
            mHold  = '0;
        end else begin
            if (gpop) mHold = mq.pop_front();
            if (pushed) mq.push_back(data);
            mFresh = pushed && wasEmpty;
        end
        if (clr) begin
            mUflag = upop;
            mUcnt  = upop ? 1 : 0;
        end else if (upop) begin
            mUflag = 1;
            if (mUcnt < 65535) mUcnt++;
        end
        @(posedge clk_i); #1;
        inport_tvalid_i  = 0;
        outport_tready_i = 0;
        flush_i          = 0;
        underrun_clr_i   = 0;
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] expData;
        expData = (mq.size() > 0) ? mq[0] : rep(mHold);
        checkVal({tag, "_valid"}, 32'(outport_tvalid_o), 32'(mq.size() > 0));
        checkVal({tag, "_data"},  outport_tdata_o, expData);
        checkVal({tag, "_level"}, 32'(level_o), 32'(mq.size()));
        checkVal({tag, "_low"},   32'(low_o), 32'(mq.size() < LOW));
        checkVal({tag, "_ready"}, 32'(inport_tready_o), 32'(mq.size() != DEPTH));
        checkVal({tag, "_uflag"}, 32'(underrun_o), 32'(mUflag));
        checkVal({tag, "_ucnt"},  32'(underrun_cnt_o), 32'(mUcnt));
    endtask

    initial begin
        int pushPct[4] = '{90, 15, 50, 60};
        int popPct[4]  = '{20, 90, 50, 55};
        logic [31:0] seq;

        inport_tlast_i = 0;
        resetDut();

        // Reset state
        checkVal("rst_valid", 32'(outport_tvalid_o), 32'd0);
        checkVal("rst_data",  outport_tdata_o, 32'd0);
        checkVal("rst_level", 32'(level_o), 32'd0);
        checkVal("rst_low",   32'(low_o), 32'd1);
        checkVal("rst_ready", 32'(inport_tready_o), 32'd1);
        checkVal("rst_uflag", 32'(underrun_o), 32'd0);
        checkVal("rst_ucnt",  32'(underrun_cnt_o), 32'd0);

        // Fresh-pop underrun, gapless push+pop at level 1, empty-pop counting, clears
        vecs[0]  = '{1'b1, 32'h11112222, 1'b0, 1'b0, 1'b1, 32'h11112222, 1, 0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h11112222, 1, 1, 1'b1};
        vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h11112222, 1, 1, 1'b1};
        vecs[3]  = '{1'b1, 32'hAAAA5555, 1'b1, 1'b0, 1'b1, 32'hAAAA5555, 1, 1, 1'b1};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hAAAA5555, 1, 0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, rep(32'hAAAA5555), 0, 0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, rep(32'hAAAA5555), 0, 1, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, rep(32'hAAAA5555), 0, 2, 1'b1};
        vecs[8]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, rep(32'hAAAA5555), 0, 3, 1'b1};
        vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, rep(32'hAAAA5555), 0, 0, 1'b0};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, rep(32'hAAAA5555), 0, 1, 1'b1};
        vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, rep(32'hAAAA5555), 0, 0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].push, vecs[i].data, vecs[i].pop, 1'b0, vecs[i].clr);
            checkVal($sformatf("vec%0d_valid", i), 32'(outport_tvalid_o), 32'(vecs[i].expValid));
            checkVal($sformatf("vec%0d_data", i),  outport_tdata_o, vecs[i].expData);
            checkVal($sformatf("vec%0d_level", i), 32'(level_o), 32'(vecs[i].expLevel));
            checkVal($sformatf("vec%0d_ucnt", i),  32'(underrun_cnt_o), 32'(vecs[i].expUcnt));
            checkVal($sformatf("vec%0d_uflag", i), 32'(underrun_o), 32'(vecs[i].expUflag));
        end

        // Fill to full, refused extra push, drain in order
        resetDut();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        end
        checkVal("full_level", 32'(level_o), 32'(DEPTH));
        checkVal("full_ready", 32'(inport_tready_o), 32'd0);
        applyStimulus(1'b1, 32'd999, 1'b0, 1'b0, 1'b0);
        checkVal("full_refused_level", 32'(level_o), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            checkVal("drain_order", outport_tdata_o, 32'(i));
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        checkVal("drain_level", 32'(level_o), 32'd0);
        checkVal("drain_low",   32'(low_o), 32'd1);
        checkVal("drain_valid", 32'(outport_tvalid_o), 32'd0);
        checkVal("drain_ucnt",  32'(underrun_cnt_o), 32'd0);

        // Flush beats a same-cycle push
        resetDut();
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 32'h5000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        end
        checkVal("preflush_level", 32'(level_o), 32'd100);
        applyStimulus(1'b1, 32'hDEAD0001, 1'b0, 1'b1, 1'b0);
        checkVal("flush_level", 32'(level_o), 32'd0);
        checkVal("flush_valid", 32'(outport_tvalid_o), 32'd0);
        checkVal("flush_data",  outport_tdata_o, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkVal("postflush_level", 32'(level_o), 32'd0);

        // Randomized traffic against the model
        resetDut();
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 1000; c++) begin
                logic push, pop, flush, clr;
                push  = ($urandom_range(0, 99) < pushPct[p]);
                pop   = ($urandom_range(0, 99) < popPct[p]);
                flush = !pop && ($urandom_range(0, 1499) == 0);
                clr   = ($urandom_range(0, 99) == 0);
                applyStimulus(push, $urandom, pop, flush, clr);
                checkOutput("rand");
            end
        end

        // I2S-like streaming at matched rates, then reset mid-stream
        resetDut();
        seq = 32'h1000;
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b1, seq, 1'b0, 1'b0, 1'b0);
            seq++;
        end
        for (int c = 0; c < 600; c++) begin
            logic push;
            push = (c % 4 == 0);
            applyStimulus(push, seq, (c % 4 == 2), 1'b0, 1'b0);
            if (push) seq++;
            checkOutput("i2s");
        end
        checkVal("i2s_ucnt", 32'(underrun_cnt_o), 32'd0);
        inport_tvalid_i = 1;
        inport_tdata_i  = seq;
        @(posedge clk_i); #2;
        rst_i = 1;
        #1;
        checkVal("midrst_valid", 32'(outport_tvalid_o), 32'd0);
        checkVal("midrst_data",  outport_tdata_o, 32'd0);
        checkVal("midrst_level", 32'(level_o), 32'd0);
        checkVal("midrst_low",   32'(low_o), 32'd1);
        checkVal("midrst_uflag", 32'(underrun_o), 32'd0);
        checkVal("midrst_ucnt",  32'(underrun_cnt_o), 32'd0);
        checkVal("midrst_ready", 32'(inport_tready_o), 32'd1);
        resetDut();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
